// File: rtl/pc_trace_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_trace_monitor_pkg
//  Purpose  : Shared definitions for the program-counter trace monitor:
//             state encoding, breakpoint slice convention, index/repeat
//             widths and the saturating-increment helper.
//  Revision : 1.0  initial release
// ============================================================================
package pc_trace_monitor_pkg;

    // Encoding is visible on the state output; values are part of the API.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_BREAK   = 3'd2,
        ST_HALT    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    localparam int c_BP_IDX_W = 4;   // up to 16 breakpoints
    localparam int c_REP_W    = 8;   // HALT_REPEATS up to 255

    // Breakpoint entry idx occupies bp_addr[bp_lsb(idx,W) +: W].
    function automatic int bp_lsb(input int idx, input int width);
        return idx * width;
    endfunction

    // Increment v as a w-bit value (w <= 32), holding at all-ones.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] mask;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v == mask) ? v : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_trace_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_trace_monitor_if
//  Purpose  : Bundle of the monitor's observation, control and status
//             signals.
//             master : the core/bench side (drives fetch, pc, breakpoint
//                      setup, timeout_limit, resume, clear; reads status)
//             slave  : the monitor side
//  Revision : 1.0  initial release
// ============================================================================
interface pc_trace_monitor_if #(
    parameter int PC_WIDTH  = 16,
    parameter int NUM_BP    = 4,
    parameter int CNT_WIDTH = 24
);
    logic                       fetch;
    logic [PC_WIDTH-1:0]        pc;
    logic [NUM_BP*PC_WIDTH-1:0] bp_addr;
    logic [NUM_BP-1:0]          bp_en;
    logic [CNT_WIDTH-1:0]       timeout_limit;
    logic                       resume;
    logic                       clear;

    logic [2:0]                 state;
    logic                       done;
    logic [3:0]                 bp_index;
    logic [PC_WIDTH-1:0]        last_pc;
    logic [CNT_WIDTH-1:0]       cycle_count;
    logic [CNT_WIDTH-1:0]       fetch_count;

    modport master (
        output fetch, pc, bp_addr, bp_en, timeout_limit, resume, clear,
        input  state, done, bp_index, last_pc, cycle_count, fetch_count
    );

    modport slave (
        input  fetch, pc, bp_addr, bp_en, timeout_limit, resume, clear,
        output state, done, bp_index, last_pc, cycle_count, fetch_count
    );
endinterface
`default_nettype wire

// File: rtl/pc_trace_monitor_bp_match.sv
`default_nettype none
// ============================================================================
//  Module   : pc_bp_match
//  Purpose  : Combinational breakpoint comparator bank with a priority
//             encoder; the lowest-numbered enabled matching entry wins.
//  Ports    : i_pc      - pc to compare
//             i_bp_addr - packed breakpoint addresses
//             i_bp_en   - per-entry enable
//             o_hit     - at least one enabled entry matches
//             o_index   - index of the lowest matching entry (0 if none)
//  Revision : 1.0  initial release
// ============================================================================
module pc_bp_match
    import pc_trace_monitor_pkg::*;
#(
    parameter int PC_WIDTH = 16,
    parameter int NUM_BP   = 4
) (
    input  wire logic [PC_WIDTH-1:0]        i_pc,
    input  wire logic [NUM_BP*PC_WIDTH-1:0] i_bp_addr,
    input  wire logic [NUM_BP-1:0]          i_bp_en,
    output logic                            o_hit,
    output logic [c_BP_IDX_W-1:0]           o_index
);
    // Scan from the top down so the last assignment is the lowest match.
    always_comb begin
        o_hit   = 1'b0;
        o_index = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (i_bp_en[i] && (i_pc == i_bp_addr[bp_lsb(i, PC_WIDTH) +: PC_WIDTH])) begin
                o_hit   = 1'b1;
                o_index = c_BP_IDX_W'(i);
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/pc_trace_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : pc_trace_monitor
//  Purpose  : Cycle-accurate program-counter observer. Tracks run cycles and
//             fetches, traps on hardware breakpoints, detects self-loops
//             (halt) and enforces a programmable cycle timeout. Terminal
//             status (HALT/TIMEOUT) is sticky until clear or reset.
//  Ports    : clk     - system clock
//             reset_n - asynchronous active-low reset
//             bus     - pc_trace_monitor_if.slave (fetch/pc/bp setup/
//                       timeout_limit/resume/clear in; status out)
//  Revision : 1.0  initial release
// ============================================================================
module pc_trace_monitor
    import pc_trace_monitor_pkg::*;
#(
    parameter int PC_WIDTH     = 16,
    parameter int NUM_BP       = 4,
    parameter int CNT_WIDTH    = 24,
    parameter int HALT_REPEATS = 3
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    pc_trace_monitor_if.slave bus
);
    state_t                r_state,   w_state_next;
    logic [CNT_WIDTH-1:0]  r_cycle,   w_cycle_next;
    logic [CNT_WIDTH-1:0]  r_fetch,   w_fetch_next;
    logic [PC_WIDTH-1:0]   r_last_pc, w_last_pc_next;
    logic [c_REP_W-1:0]    r_rep,     w_rep_next;
    logic                  r_skip,    w_skip_next;
    logic [c_BP_IDX_W-1:0] r_bp_idx,  w_bp_idx_next;
    logic                  r_done,    w_done_next;

    logic                  w_bp_hit;
    logic [c_BP_IDX_W-1:0] w_bp_idx;
    logic [CNT_WIDTH-1:0]  w_cycle_inc;
    logic [CNT_WIDTH-1:0]  w_fetch_inc;
    logic [CNT_WIDTH:0]    w_cycle_plus1;
    logic [c_REP_W-1:0]    w_rep_upd;

    pc_bp_match #(
        .PC_WIDTH (PC_WIDTH),
        .NUM_BP   (NUM_BP)
    ) u_bp_match (
        .i_pc      (bus.pc),
        .i_bp_addr (bus.bp_addr),
        .i_bp_en   (bus.bp_en),
        .o_hit     (w_bp_hit),
        .o_index   (w_bp_idx)
    );

    assign w_cycle_inc   = CNT_WIDTH'(sat_inc(32'(r_cycle), CNT_WIDTH));
    assign w_fetch_inc   = CNT_WIDTH'(sat_inc(32'(r_fetch), CNT_WIDTH));
    // Extra bit so a saturated counter can never alias a small limit.
    assign w_cycle_plus1 = {1'b0, r_cycle} + (CNT_WIDTH+1)'(1);
    assign w_rep_upd     = (bus.pc == r_last_pc) ? c_REP_W'(sat_inc(32'(r_rep), c_REP_W))
                                                 : c_REP_W'(1);

    always_comb begin
        w_state_next   = r_state;
        w_cycle_next   = r_cycle;
        w_fetch_next   = r_fetch;
        w_last_pc_next = r_last_pc;
        w_rep_next     = r_rep;
        w_skip_next    = r_skip;
        w_bp_idx_next  = r_bp_idx;

        case (r_state)
            ST_IDLE: begin
                if (bus.fetch) begin
                    w_state_next   = ST_RUN;
                    w_last_pc_next = bus.pc;
                    w_fetch_next   = CNT_WIDTH'(1);
                    w_rep_next     = c_REP_W'(1);
                end
            end
            ST_RUN: begin
                w_cycle_next = w_cycle_inc;
                if (bus.fetch) begin
                    w_fetch_next   = w_fetch_inc;
                    w_last_pc_next = bus.pc;
                    w_rep_next     = w_rep_upd;
                    w_skip_next    = 1'b0;
                end
                // Priority: breakpoint > halt > timeout.
                if (bus.fetch && w_bp_hit && !r_skip) begin
                    w_state_next  = ST_BREAK;
                    w_bp_idx_next = w_bp_idx;
                end else if (bus.fetch && (w_rep_upd == c_REP_W'(HALT_REPEATS))) begin
                    w_state_next = ST_HALT;
                end else if ((bus.timeout_limit != '0) &&
                             (w_cycle_plus1 == {1'b0, bus.timeout_limit})) begin
                    w_state_next = ST_TIMEOUT;
                end
            end
            ST_BREAK: begin
                // Counters frozen; skip the trap on the first fetch back in RUN.
                if (bus.resume) begin
                    w_state_next = ST_RUN;
                    w_skip_next  = 1'b1;
                end
            end
            default: ;  // HALT / TIMEOUT are sticky
        endcase

        if (bus.clear) begin
            w_state_next   = ST_IDLE;
            w_cycle_next   = '0;
            w_fetch_next   = '0;
            w_last_pc_next = '0;
            w_rep_next     = '0;
            w_skip_next    = 1'b0;
            w_bp_idx_next  = '0;
        end

        w_done_next = (w_state_next == ST_HALT) || (w_state_next == ST_TIMEOUT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_cycle   <= '0;
            r_fetch   <= '0;
            r_last_pc <= '0;
            r_rep     <= '0;
            r_skip    <= 1'b0;
            r_bp_idx  <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cycle   <= w_cycle_next;
            r_fetch   <= w_fetch_next;
            r_last_pc <= w_last_pc_next;
            r_rep     <= w_rep_next;
            r_skip    <= w_skip_next;
            r_bp_idx  <= w_bp_idx_next;
            r_done    <= w_done_next;
        end
    end

    assign bus.state       = r_state;
    assign bus.done        = r_done;
    assign bus.bp_index    = r_bp_idx;
    assign bus.last_pc     = r_last_pc;
    assign bus.cycle_count = r_cycle;
    assign bus.fetch_count = r_fetch;
endmodule
`default_nettype wire

// File: tb/tb_pc_trace_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_trace_monitor
//  Purpose  : Self-checking bench for pc_trace_monitor. Instance A uses the
//             default parameters; B uses HALT_REPEATS=2; C uses CNT_WIDTH=4.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_trace_monitor;
    logic clk;
    logic reset_n;

    int total;
    int bad;

    pc_trace_monitor_if #(.PC_WIDTH(16), .NUM_BP(4), .CNT_WIDTH(24)) ifa ();
    pc_trace_monitor_if #(.PC_WIDTH(16), .NUM_BP(4), .CNT_WIDTH(24)) ifb ();
    pc_trace_monitor_if #(.PC_WIDTH(16), .NUM_BP(4), .CNT_WIDTH(4))  ifc ();

    pc_trace_monitor #(.PC_WIDTH(16), .NUM_BP(4), .CNT_WIDTH(24), .HALT_REPEATS(3))
        u_dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
    pc_trace_monitor #(.PC_WIDTH(16), .NUM_BP(4), .CNT_WIDTH(24), .HALT_REPEATS(2))
        u_dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));
    pc_trace_monitor #(.PC_WIDTH(16), .NUM_BP(4), .CNT_WIDTH(4),  .HALT_REPEATS(3))
        u_dut_c (.clk(clk), .reset_n(reset_n), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fetch;
        logic [15:0] pc;
        logic        resume;
        logic        clear;
        logic [2:0]  e_state;
        logic        e_done;
        logic [15:0] e_last_pc;
        logic [23:0] e_fcnt;
        logic [3:0]  e_bp;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Halt sequence, then breakpoint/skip sequence (bp1=bp3=0x20).
        //           fetch pc       res   clr   state done last_pc fcnt bp
        vecs[0]  = '{1'b1, 16'h000C, 1'b0, 1'b0, 3'd1, 1'b0, 16'h000C, 24'd1, 4'd0};
        vecs[1]  = '{1'b1, 16'h000E, 1'b0, 1'b0, 3'd1, 1'b0, 16'h000E, 24'd2, 4'd0};
        vecs[2]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 3'd1, 1'b0, 16'h0010, 24'd3, 4'd0};
        vecs[3]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 3'd1, 1'b0, 16'h0010, 24'd4, 4'd0};
        vecs[4]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 3'd3, 1'b1, 16'h0010, 24'd5, 4'd0};
        vecs[5]  = '{1'b1, 16'h0012, 1'b0, 1'b0, 3'd3, 1'b1, 16'h0010, 24'd5, 4'd0};
        vecs[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 3'd0, 1'b0, 16'h0000, 24'd0, 4'd0};
        vecs[7]  = '{1'b1, 16'h001E, 1'b0, 1'b0, 3'd1, 1'b0, 16'h001E, 24'd1, 4'd0};
        vecs[8]  = '{1'b1, 16'h0020, 1'b0, 1'b0, 3'd2, 1'b0, 16'h0020, 24'd2, 4'd1};
        vecs[9]  = '{1'b1, 16'h0024, 1'b0, 1'b0, 3'd2, 1'b0, 16'h0020, 24'd2, 4'd1};
        vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd1, 1'b0, 16'h0020, 24'd2, 4'd1};
        vecs[11] = '{1'b1, 16'h0020, 1'b0, 1'b0, 3'd1, 1'b0, 16'h0020, 24'd3, 4'd1};
        vecs[12] = '{1'b1, 16'h0022, 1'b0, 1'b0, 3'd1, 1'b0, 16'h0022, 24'd4, 4'd1};
        vecs[13] = '{1'b1, 16'h0020, 1'b0, 1'b0, 3'd2, 1'b0, 16'h0020, 24'd5, 4'd1};
        vecs[14] = '{1'b1, 16'h0030, 1'b0, 1'b1, 3'd0, 1'b0, 16'h0000, 24'd0, 4'd0};
        vecs[15] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0000, 24'd0, 4'd0};

        ifa.fetch = 1'b0; ifa.pc = '0; ifa.resume = 1'b0; ifa.clear = 1'b0;
        ifa.timeout_limit = '0;
        ifa.bp_addr = {16'h0020, 16'h0000, 16'h0020, 16'h0000};
        ifa.bp_en   = 4'b1010;
        ifb.fetch = 1'b0; ifb.pc = '0; ifb.resume = 1'b0; ifb.clear = 1'b0;
        ifb.timeout_limit = '0;
        ifb.bp_addr = {16'h0000, 16'h0000, 16'h0000, 16'h0040};
        ifb.bp_en   = 4'b0001;
        ifc.fetch = 1'b0; ifc.pc = '0; ifc.resume = 1'b0; ifc.clear = 1'b0;
        ifc.timeout_limit = '0;
        ifc.bp_addr = '0;
        ifc.bp_en   = '0;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        chk("reset_state", 32'(ifa.state), 32'd0);
        chk("reset_done",  32'(ifa.done), 32'd0);

        for (int i = 0; i < 16; i++) begin
            ifa.fetch  = vecs[i].fetch;
            ifa.pc     = vecs[i].pc;
            ifa.resume = vecs[i].resume;
            ifa.clear  = vecs[i].clear;
            tick();
            chk($sformatf("v%0d_state", i),   32'(ifa.state),       32'(vecs[i].e_state));
            chk($sformatf("v%0d_done", i),    32'(ifa.done),        32'(vecs[i].e_done));
            chk($sformatf("v%0d_last_pc", i), 32'(ifa.last_pc),     32'(vecs[i].e_last_pc));
            chk($sformatf("v%0d_fcnt", i),    32'(ifa.fetch_count), 32'(vecs[i].e_fcnt));
            chk($sformatf("v%0d_bp", i),      32'(ifa.bp_index),    32'(vecs[i].e_bp));
        end
        ifa.fetch = 1'b0; ifa.resume = 1'b0; ifa.clear = 1'b0;

        // Timeout at 100 cycles, pc stepping by 2, breakpoints off.
        ifa.bp_en = '0;
        ifa.timeout_limit = 24'd100;
        ifa.fetch = 1'b1;
        ifa.pc    = 16'h0000;
        tick();                               // IDLE -> RUN, cycle_count 0
        for (int k = 1; k <= 99; k++) begin
            ifa.pc = 16'(2 * k);
            tick();
        end
        chk("to_pre_state", 32'(ifa.state),       32'd1);
        chk("to_pre_cycle", 32'(ifa.cycle_count), 32'd99);
        ifa.pc = 16'd200;
        tick();
        chk("to_state", 32'(ifa.state),       32'd4);
        chk("to_cycle", 32'(ifa.cycle_count), 32'd100);
        chk("to_done",  32'(ifa.done),        32'd1);
        ifa.pc = 16'd202;
        tick();
        chk("to_sticky_cycle", 32'(ifa.cycle_count), 32'd100);
        chk("to_sticky_fcnt",  32'(ifa.fetch_count), 32'd101);

        // Clear together with fetch while in TIMEOUT.
        ifa.clear = 1'b1;
        ifa.pc    = 16'h0300;
        tick();
        ifa.clear = 1'b0;
        chk("clr_state", 32'(ifa.state),       32'd0);
        chk("clr_cycle", 32'(ifa.cycle_count), 32'd0);
        chk("clr_fcnt",  32'(ifa.fetch_count), 32'd0);
        chk("clr_done",  32'(ifa.done),        32'd0);

        // Timeout disabled: 1000 RUN cycles stay in RUN.
        ifa.timeout_limit = '0;
        ifa.pc = 16'h0000;
        tick();
        for (int k = 1; k <= 1000; k++) begin
            ifa.pc = 16'(2 * k);
            tick();
        end
        chk("noto_state", 32'(ifa.state),       32'd1);
        chk("noto_cycle", 32'(ifa.cycle_count), 32'd1000);
        chk("noto_fcnt",  32'(ifa.fetch_count), 32'd1001);

        // Asynchronous reset mid-RUN, away from any clock edge.
        #2 reset_n = 1'b0;
        #1;
        chk("arst_state", 32'(ifa.state),       32'd0);
        chk("arst_cycle", 32'(ifa.cycle_count), 32'd0);
        chk("arst_fcnt",  32'(ifa.fetch_count), 32'd0);
        chk("arst_pc",    32'(ifa.last_pc),     32'd0);
        chk("arst_done",  32'(ifa.done),        32'd0);
        ifa.fetch = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (10) tick();
        chk("idle_state", 32'(ifa.state),       32'd0);
        chk("idle_cycle", 32'(ifa.cycle_count), 32'd0);

        // HALT_REPEATS=2 with breakpoint at 0x40: breakpoint beats halt.
        ifb.fetch = 1'b1;
        ifb.pc    = 16'h0040;
        tick();
        chk("sim_first_state", 32'(ifb.state), 32'd1);
        tick();
        ifb.fetch = 1'b0;
        chk("sim_state", 32'(ifb.state),    32'd2);
        chk("sim_bp",    32'(ifb.bp_index), 32'd0);
        chk("sim_done",  32'(ifb.done),     32'd0);

        // Saturation with 4-bit counters: 20 distinct fetches.
        for (int k = 0; k < 20; k++) begin
            ifc.fetch = 1'b1;
            ifc.pc    = 16'(k);
            tick();
        end
        ifc.fetch = 1'b0;
        chk("sat_state", 32'(ifc.state),       32'd1);
        chk("sat_fcnt",  32'(ifc.fetch_count), 32'd15);
        chk("sat_cycle", 32'(ifc.cycle_count), 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the main sequence stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, checks done %0d", total);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
